// File: rtl/multi_barrel_shifter_mux.sv
// Barrel rotator: 2**N-bit word rotated left or right by 0..2**N-1 positions,
// built from cascaded 2:1 mux stages, with a registered output.
module multi_barrel_shifter_mux #(
    parameter int unsigned N = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2**N-1:0] a,
    input  logic [N-1:0]   amt,
    input  logic           lr,
    output logic [2**N-1:0] y
);

    localparam int unsigned W = 2**N;

    // Stage k output of each rotator; index 0 is the raw input word.
    logic [W-1:0] rr_c [0:N];
    logic [W-1:0] rl_c [0:N];
    logic [W-1:0] sel_c;

    assign rr_c[0] = a;
    assign rl_c[0] = a;

    // Each stage conditionally rotates by 2**k; bit indices wrap modulo W.
    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int unsigned SH = 2**k;
        for (genvar i = 0; i < W; i++) begin : g_bit
            localparam int unsigned IR = (i + SH) % W;
            localparam int unsigned IL = (i + W - SH) % W;
            assign rr_c[k+1][i] = amt[k] ? rr_c[k][IR] : rr_c[k][i];
            assign rl_c[k+1][i] = amt[k] ? rl_c[k][IL] : rl_c[k][i];
        end
    end

    // Direction select: lr=1 takes the left rotator.
    assign sel_c = lr ? rl_c[N] : rr_c[N];

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            y <= '0;
        end else begin
            y <= sel_c;
        end
    end

endmodule

// File: tb/tb_multi_barrel_shifter_mux.sv
// Scoreboarded bench for multi_barrel_shifter_mux (N=3): directed vectors,
// an exhaustive sweep with a mid-stream reset pulse, and random vectors.
module tb_multi_barrel_shifter_mux;

    localparam int unsigned N = 3;
    localparam int unsigned W = 2**N;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [N-1:0] amt;
    logic         lr;
    logic [W-1:0] y;

    logic [W-1:0] exp_q [$];
    string        name_q [$];
    int           tests;
    int           fails;

    multi_barrel_shifter_mux #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .amt   (amt),
        .lr    (lr),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rotate from the index rule: right y[i]=a[(i+amt)%W], left y[i]=a[(i-amt)%W].
    function automatic logic [W-1:0] ref_rot(input logic [W-1:0] av, input int am, input logic l);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (l) r[i] = av[(i - am + W) % W];
            else   r[i] = av[(i + am) % W];
        end
        return r;
    endfunction

    // Apply one input set on the falling edge and record what y must show after the next rise.
    task automatic drive(input logic rst, input logic [W-1:0] av, input logic [N-1:0] am,
                         input logic l, input string nm);
        @(negedge clk);
        reset = rst;
        a     = av;
        amt   = am;
        lr    = l;
        exp_q.push_back(rst ? '0 : ref_rot(av, int'(am), l));
        name_q.push_back(nm);
    endtask

    // Monitor: every rising edge produces one result, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            tests++;
            if (y !== e) begin
                fails++;
                $display("FAIL %s: y=%b expected=%b", nm, y, e);
            end
        end
    end

    typedef struct {
        logic [W-1:0] av;
        logic [N-1:0] am;
        logic         l;
        logic [W-1:0] want;
    } vec_t;

    vec_t dir [10];

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        a     = '0;
        amt   = '0;
        lr    = 1'b0;

        // Reset held for two edges with non-zero inputs.
        drive(1'b1, 8'hFF, 3'd3, 1'b0, "reset_hold0");
        drive(1'b1, 8'hFF, 3'd3, 1'b0, "reset_hold1");

        // Directed vectors with literal expected results.
        dir[0] = '{8'b01010110, 3'd3, 1'b0, 8'b11001010};
        dir[1] = '{8'b11110000, 3'd1, 1'b0, 8'b01111000};
        dir[2] = '{8'b11111000, 3'd2, 1'b0, 8'b00111110};
        dir[3] = '{8'b01110101, 3'd4, 1'b0, 8'b01010111};
        dir[4] = '{8'b01010110, 3'd3, 1'b1, 8'b10110010};
        dir[5] = '{8'b11110000, 3'd1, 1'b1, 8'b11100001};
        dir[6] = '{8'b11111000, 3'd2, 1'b1, 8'b11100011};
        dir[7] = '{8'b01110101, 3'd4, 1'b1, 8'b01010111};
        dir[8] = '{8'b10100011, 3'd0, 1'b0, 8'b10100011};
        dir[9] = '{8'b10100011, 3'd0, 1'b1, 8'b10100011};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            reset = 1'b0;
            a     = dir[i].av;
            amt   = dir[i].am;
            lr    = dir[i].l;
            exp_q.push_back(dir[i].want);
            name_q.push_back($sformatf("directed%0d", i));
        end

        // Exhaustive sweep, new input every cycle, with one reset pulse mid-stream.
        for (int av = 0; av < 256; av++) begin
            for (int am = 0; am < 8; am++) begin
                for (int l = 0; l < 2; l++) begin
                    if (av == 100 && am == 5 && l == 0)
                        drive(1'b1, W'(av), N'(am), 1'b1, "midreset");
                    drive(1'b0, W'(av), N'(am), l[0], "sweep");
                end
            end
        end

        // Random vectors.
        for (int i = 0; i < 200; i++)
            drive(1'b0, W'($urandom), N'($urandom_range(0, W-1)), 1'($urandom), "random");

        // Drain: every pushed expectation must have been consumed.
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
